// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one single-port SRAM between the host bridge (un-stallable
//            read/write strobes) and the compute engine (req/gnt handshake).
//            Host writes are posted into a small FIFO write buffer. Host reads
//            are forwarded from that buffer on an address hit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   host_wr_*              host write strobe / address / data (posted)
//   host_rd_*              host read strobe / address, data returned next cycle
//   eng_req/we/addr/wdata  engine access request, held until eng_gnt
//   eng_gnt                engine access accepted this cycle
//   eng_rvalid/eng_rdata   engine read return, one cycle after grant
//   mem_*                  SRAM macro interface (read latency 1)
//   wbuf_empty             write buffer holds no entries
//   wbuf_ovf               sticky: a host write was dropped
//   eng_stall_cnt          engine stall cycles   (live with SRAM_ARB_STATS_EN)
//   fwd_hit_cnt            forwarded host reads  (live with SRAM_ARB_STATS_EN)
// Optional feature macro: SRAM_ARB_STATS_EN (saturating statistics counters;
// without it both counter outputs are tied to zero).
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_rd_en,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wbuf_empty,
  output logic              wbuf_ovf,
  output logic [31:0]       eng_stall_cnt,
  output logic [31:0]       fwd_hit_cnt
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  // Who owns the SRAM read data arriving next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_ENG  = 2'd2
  } owner_e;

  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  owner_e            owner_q, owner_d;
  logic              fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic              ovf_q, ovf_d;

  logic              full;
  logic              empty;
  logic              drain;
  logic              push;
  logic [PTR_W-1:0]  idx;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Fixed-priority port selection: host read, forced drain when full,
  // engine, opportunistic drain, idle.
  always_comb begin : port_select
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wb_addr_q[head_q];
    mem_wdata = wb_data_q[head_q];
    eng_gnt   = 1'b0;
    drain     = 1'b0;
    owner_d   = OWN_NONE;
    if (host_rd_en) begin
      mem_en   = 1'b1;
      mem_addr = host_rd_addr;
      owner_d  = OWN_HOST;
    end else if (full) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
      drain  = 1'b1;
    end else if (eng_req) begin
      eng_gnt   = 1'b1;
      mem_en    = 1'b1;
      mem_we    = eng_we;
      mem_addr  = eng_addr;
      mem_wdata = eng_wdata;
      if (!eng_we) begin
        owner_d = OWN_ENG;
      end
    end else if (!empty) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
      drain  = 1'b1;
    end
  end

  // A full buffer can still accept a write if it drains in the same cycle;
  // only a colliding host read (which steals the drain slot) drops writes.
  assign push = host_wr_en & (~full | drain);

  always_comb begin : wbuf_ctrl
    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    ovf_d   = ovf_q | (host_wr_en & ~push);
  end

  // Walk valid entries oldest to newest so the newest match wins; the entry
  // being pushed this cycle is newer than all of them. A draining head entry
  // is still counted because its SRAM write has not landed yet.
  always_comb begin : fwd_lookup
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    idx        = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_addr_q[idx] == host_rd_addr)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wb_data_q[idx];
      end
    end
    if (push && (host_wr_addr == host_rd_addr)) begin
      fwd_hit_d  = 1'b1;
      fwd_data_d = host_wr_data;
    end
    if (!host_rd_en) begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      owner_q    <= OWN_NONE;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      owner_q    <= owner_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk) begin : wbuf_store
    if (push) begin
      wb_addr_q[tail_q] <= host_wr_addr;
      wb_data_q[tail_q] <= host_wr_data;
    end
  end

  assign host_rd_data = (owner_q == OWN_HOST) ? (fwd_hit_q ? fwd_data_q : mem_rdata) : '0;
  assign eng_rvalid   = (owner_q == OWN_ENG);
  assign eng_rdata    = eng_rvalid ? mem_rdata : '0;
  assign wbuf_empty   = empty;
  assign wbuf_ovf     = ovf_q;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;

  always_comb begin : stats_next
    stall_cnt_d = stall_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    if (eng_req && !eng_gnt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (fwd_hit_d && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stats_regs
    if (!rst_n) begin
      stall_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  assign eng_stall_cnt = stall_cnt_q;
  assign fwd_hit_cnt   = hit_cnt_q;
`else
  assign eng_stall_cnt = '0;
  assign fwd_hit_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Self-checking bench for sram_port_arbiter: directed scenarios
//            plus randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_rd_en = 1'b0;
  logic [AW-1:0] host_rd_addr = '0;
  logic [DW-1:0] host_rd_data;
  logic          eng_req = 1'b0;
  logic          eng_we = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic [DW-1:0] eng_wdata = '0;
  logic          eng_gnt;
  logic          eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          wbuf_empty;
  logic          wbuf_ovf;
  logic [31:0]   eng_stall_cnt;
  logic [31:0]   fwd_hit_cnt;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wbuf_empty(wbuf_empty), .wbuf_ovf(wbuf_ovf),
    .eng_stall_cnt(eng_stall_cnt), .fwd_hit_cnt(fwd_hit_cnt)
  );

  // Power-up contents of the SRAM, shared by the macro model and the reference.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 13'h0100) return 32'hCAFE0001;
    return 32'h5A000000 ^ {19'd0, a};
  endfunction

  // Behavioural SRAM macro driven only by the DUT.
  logic [DW-1:0] sram   [0:(1<<AW)-1];
  bit            sram_v [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr]   <= mem_wdata;
        sram_v[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= sram_v[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          wq[$];
  logic [DW-1:0] ref_mem [int];
  int            ref_owner;   // 0 none, 1 host, 2 engine
  logic [DW-1:0] ref_ret;
  logic          ref_ovf;
  int unsigned   ref_stall, ref_hits;

  logic          e_en, e_we, e_gnt, e_drain, e_rv, e_empty;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_hrd, e_erd;
  logic [31:0]   e_stall, e_hits;

  int total, bad;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic model_reset();
    wq.delete();
    ref_owner = 0;
    ref_ret   = '0;
    ref_ovf   = 1'b0;
    ref_stall = 0;
    ref_hits  = 0;
  endtask

  // Expected outputs for the current cycle from model state and inputs.
  task automatic model_eval();
    e_en = 1'b0; e_we = 1'b0; e_gnt = 1'b0; e_drain = 1'b0;
    e_addr = '0; e_wdata = '0;
    if (host_rd_en) begin
      e_en = 1'b1; e_addr = host_rd_addr;
    end else if ((wq.size() == DEPTH) || (!eng_req && wq.size() > 0)) begin
      e_en = 1'b1; e_we = 1'b1; e_drain = 1'b1;
      e_addr = wq[0].a; e_wdata = wq[0].d;
    end else if (eng_req) begin
      e_gnt = 1'b1; e_en = 1'b1; e_we = eng_we;
      e_addr = eng_addr; e_wdata = eng_wdata;
    end
    e_hrd   = (ref_owner == 1) ? ref_ret : '0;
    e_rv    = (ref_owner == 2);
    e_erd   = e_rv ? ref_ret : '0;
    e_empty = (wq.size() == 0);
`ifdef SRAM_ARB_STATS_EN
    e_stall = ref_stall;
    e_hits  = ref_hits;
`else
    e_stall = '0;
    e_hits  = '0;
`endif
  endtask

  // Advance the model across one clock edge.
  task automatic model_commit();
    bit            full_now;
    bit            hit;
    logic [DW-1:0] hd;
    int            nxt;
    full_now = (wq.size() == DEPTH);
    hit = 1'b0;
    nxt = 0;
    if (host_rd_en) begin
      hd = ref_rd(host_rd_addr);
      foreach (wq[i]) if (wq[i].a == host_rd_addr) begin hit = 1'b1; hd = wq[i].d; end
      if (host_wr_en && !full_now && host_wr_addr == host_rd_addr) begin
        hit = 1'b1; hd = host_wr_data;
      end
      nxt = 1; ref_ret = hd;
      if (hit && ref_hits != 32'hFFFFFFFF) ref_hits++;
    end else if (e_gnt && !eng_we) begin
      nxt = 2; ref_ret = ref_rd(eng_addr);
    end
    if (eng_req && !e_gnt && ref_stall != 32'hFFFFFFFF) ref_stall++;
    if (e_gnt && eng_we) ref_mem[int'(eng_addr)] = eng_wdata;
    if (e_drain) begin
      ref_mem[int'(wq[0].a)] = wq[0].d;
      void'(wq.pop_front());
    end
    if (host_wr_en) begin
      if (!full_now || e_drain) wq.push_back({host_wr_addr, host_wr_data});
      else ref_ovf = 1'b1;
    end
    ref_owner = nxt;
  endtask

  task automatic idle();
    host_wr_en = 1'b0; host_rd_en = 1'b0; eng_req = 1'b0; eng_we = 1'b0;
  endtask

  task automatic to_check();
    @(negedge clk);
    model_eval();
  endtask

  task automatic to_next();
    @(posedge clk);
    if (rst_n) model_commit();
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    idle();
    to_check();
    while (!wbuf_empty && n < 20) begin to_next(); to_check(); n++; end
    total++;
    if (wbuf_empty !== 1'b1) begin
      bad++; $display("FAIL %s_drain_timeout wbuf_empty=%b required=1", tag, wbuf_empty);
    end
    to_next();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({wbuf_empty, wbuf_ovf, eng_rvalid, mem_en, eng_gnt} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got=%b required=10000",
                      {wbuf_empty, wbuf_ovf, eng_rvalid, mem_en, eng_gnt});
    end
    total++;
    if ({host_rd_data, eng_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_data host=%h eng=%h required=0", host_rd_data, eng_rdata);
    end
    total++;
    if ({eng_stall_cnt, fwd_hit_cnt} !== 64'd0) begin
      bad++; $display("FAIL reset_stats stall=%0d hits=%0d required=0", eng_stall_cnt, fwd_hit_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_drain();
    host_wr_en = 1'b1; host_wr_addr = 13'h0010; host_wr_data = 32'hDEADBEEF;
    to_check(); to_next();
    idle(); to_check();
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'h0010, 32'hDEADBEEF}) begin
      bad++; $display("FAIL wr_drain en=%b we=%b addr=%h data=%h required 1 1 0010 deadbeef",
                      mem_en, mem_we, mem_addr, mem_wdata);
    end
    to_next(); to_check();
    total++;
    if (wbuf_empty !== 1'b1) begin
      bad++; $display("FAIL wr_drain_empty got=%b required=1", wbuf_empty);
    end
    to_next();
  endtask

  task automatic test_forward();
    eng_req = 1'b1; eng_we = 1'b1; eng_addr = 13'h0300; eng_wdata = 32'h00000033;
    host_wr_en = 1'b1; host_wr_addr = 13'h0020; host_wr_data = 32'h11111111;
    to_check();
    total++;
    if ({eng_gnt, mem_addr} !== {1'b1, 13'h0300}) begin
      bad++; $display("FAIL fwd_eng_gnt1 gnt=%b addr=%h required 1 0300", eng_gnt, mem_addr);
    end
    to_next();
    host_wr_data = 32'h22222222;
    to_check();
    total++;
    if (eng_gnt !== 1'b1) begin
      bad++; $display("FAIL fwd_eng_gnt2 got=%b required=1", eng_gnt);
    end
    to_next();
    host_wr_en = 1'b0; host_rd_en = 1'b1; host_rd_addr = 13'h0020;
    to_check(); to_next();
    idle(); to_check();
    total++;
    if (host_rd_data !== 32'h22222222) begin
      bad++; $display("FAIL fwd_data got=%h required=22222222", host_rd_data);
    end
    to_next();
    wait_empty("fwd");
  endtask

  task automatic test_eng_read();
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0100;
    to_check();
    total++;
    if (eng_gnt !== 1'b1) begin
      bad++; $display("FAIL eng_rd_gnt got=%b required=1", eng_gnt);
    end
    to_next();
    idle(); to_check();
    total++;
    if ({eng_rvalid, eng_rdata} !== {1'b1, 32'hCAFE0001}) begin
      bad++; $display("FAIL eng_rd_data rvalid=%b data=%h required 1 cafe0001", eng_rvalid, eng_rdata);
    end
    to_next();
  endtask

  task automatic test_full_priority();
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0140;
    for (int k = 0; k < DEPTH; k++) begin
      host_wr_en = 1'b1; host_wr_addr = 13'h0040 + 13'(k); host_wr_data = $urandom;
      to_check();
      total++;
      if (eng_gnt !== 1'b1) begin
        bad++; $display("FAIL full_gnt_fill%0d got=%b required=1", k, eng_gnt);
      end
      to_next();
    end
    host_wr_addr = 13'h0044; host_wr_data = 32'h55555555;
    to_check();
    total++;
    if ({eng_gnt, mem_we, mem_addr} !== {1'b0, 1'b1, 13'h0040}) begin
      bad++; $display("FAIL full_deny gnt=%b we=%b addr=%h required 0 1 0040", eng_gnt, mem_we, mem_addr);
    end
    to_next();
    host_wr_en = 1'b0; to_check();
    total++;
    if ({wbuf_ovf, eng_gnt} !== 2'b00) begin
      bad++; $display("FAIL full_no_ovf ovf=%b gnt=%b required 0 0", wbuf_ovf, eng_gnt);
    end
    to_next(); to_check();
    total++;
    if (eng_gnt !== 1'b1) begin
      bad++; $display("FAIL full_regrant got=%b required=1", eng_gnt);
    end
    to_next();
    wait_empty("full");
  endtask

  task automatic test_collision();
    host_rd_en = 1'b1; host_rd_addr = 13'h0005;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0200;
    to_check();
    total++;
    if (eng_gnt !== 1'b0) begin
      bad++; $display("FAIL coll_deny got=%b required=0", eng_gnt);
    end
    to_next();
    host_rd_en = 1'b0; to_check();
    total++;
    if ({host_rd_data, eng_gnt} !== {32'h5A000005, 1'b1}) begin
      bad++; $display("FAIL coll_host data=%h gnt=%b required 5a000005 1", host_rd_data, eng_gnt);
    end
    to_next();
    idle(); to_check();
    total++;
    if ({eng_rvalid, eng_rdata} !== {1'b1, 32'h5A000200}) begin
      bad++; $display("FAIL coll_eng rvalid=%b data=%h required 1 5a000200", eng_rvalid, eng_rdata);
    end
    to_next();
  endtask

  task automatic test_overflow_reset();
    for (int k = 0; k <= DEPTH; k++) begin
      host_rd_en = 1'b1; host_rd_addr = 13'h0060 + 13'(k);
      host_wr_en = 1'b1; host_wr_addr = 13'h0070 + 13'(k); host_wr_data = 32'hA0000000 + k;
      if (k == DEPTH) host_rd_addr = 13'h0070;
      to_check();
      total++;
      if ({mem_en, mem_we} !== 2'b10) begin
        bad++; $display("FAIL ovf_read_wins%0d en=%b we=%b required 1 0", k, mem_en, mem_we);
      end
      to_next();
    end
    idle(); to_check();
    total++;
    if ({wbuf_ovf, mem_we, host_rd_data} !== {1'b1, 1'b1, 32'hA0000000}) begin
      bad++; $display("FAIL ovf_set ovf=%b we=%b rd=%h required 1 1 a0000000", wbuf_ovf, mem_we, host_rd_data);
    end
    to_next(); to_check();
    total++;
    if ({wbuf_ovf, mem_we} !== 2'b11) begin
      bad++; $display("FAIL ovf_sticky ovf=%b we=%b required 1 1", wbuf_ovf, mem_we);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({wbuf_empty, wbuf_ovf, eng_rvalid, mem_en, host_rd_data, eng_rdata} !== {4'b1000, 64'd0}) begin
      bad++; $display("FAIL async_reset empty=%b ovf=%b rv=%b en=%b hrd=%h erd=%h required 1 0 0 0 0 0",
                      wbuf_empty, wbuf_ovf, eng_rvalid, mem_en, host_rd_data, eng_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    to_next(); to_check();
    total++;
    if ({wbuf_empty, wbuf_ovf, mem_en} !== 3'b100) begin
      bad++; $display("FAIL post_reset empty=%b ovf=%b en=%b required 1 0 0", wbuf_empty, wbuf_ovf, mem_en);
    end
    to_next();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      host_rd_en   = (r < 25);
      host_wr_en   = (r >= 25 && r < 55);
      host_rd_addr = 13'($urandom_range(0, 15));
      host_wr_addr = 13'($urandom_range(0, 15));
      host_wr_data = $urandom;
      if (!eng_req && $urandom_range(0, 2) == 0) begin
        eng_req = 1'b1; eng_we = 1'($urandom_range(0, 1));
        eng_addr = 13'($urandom_range(0, 15)); eng_wdata = $urandom;
      end
      to_check();
      total++;
      if ({mem_en, eng_gnt, eng_rvalid, wbuf_empty, wbuf_ovf} !== {e_en, e_gnt, e_rv, e_empty, ref_ovf}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d got=%b required=%b", c,
                        {mem_en, eng_gnt, eng_rvalid, wbuf_empty, wbuf_ovf}, {e_en, e_gnt, e_rv, e_empty, ref_ovf});
      end
      if (e_en) begin
        total++;
        if ({mem_we, mem_addr} !== {e_we, e_addr}) begin
          bad++; $display("FAIL rnd_port cyc=%0d we=%b addr=%h required %b %h", c, mem_we, mem_addr, e_we, e_addr);
        end
      end
      if (e_en && e_we) begin
        total++;
        if (mem_wdata !== e_wdata) begin
          bad++; $display("FAIL rnd_wdata cyc=%0d got=%h required=%h", c, mem_wdata, e_wdata);
        end
      end
      total++;
      if ({host_rd_data, eng_rdata} !== {e_hrd, e_erd}) begin
        bad++; $display("FAIL rnd_rdata cyc=%0d host=%h eng=%h required %h %h", c, host_rd_data, eng_rdata, e_hrd, e_erd);
      end
      to_next();
      if (e_gnt) eng_req = 1'b0;
    end
    idle(); to_check();
    total++;
    if ({eng_stall_cnt, fwd_hit_cnt} !== {e_stall, e_hits}) begin
      bad++; $display("FAIL rnd_stats stall=%0d hits=%0d required %0d %0d", eng_stall_cnt, fwd_hit_cnt, e_stall, e_hits);
    end
    to_next();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_drain();
    test_forward();
    test_eng_read();
    test_full_priority();
    test_collision();
    test_overflow_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
